// File: rtl/mall_door_sensor.sv
// Doorway direction decoder: two-flop sync + debounce per IR beam, then an FSM
// that turns the {A,B} sequence into entry/exit/error pulses. Optional stall timeout: MALL_DOOR_TIMEOUT_EN.
module mall_door_sensor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1023
) (
  input  logic clock,
  input  logic reset,
  input  logic beam_a,
  input  logic beam_b,
  output logic entry_pulse,
  output logic exit_pulse,
  output logic err_pulse,
  output logic busy,
  output logic beam_a_db,
  output logic beam_b_db
);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 1023) begin : g_bad_param
    $error("mall_door_sensor: parameter out of range");
  end

  typedef enum logic [2:0] {
    IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_BA, OUT_A, WAIT_CLR
  } state_e;

  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

  // Bit 1 carries beam A and bit 0 beam B, so db_q is directly the FSM pair.
  logic [1:0]      sync1_q, sync2_q, db_q, db_d;
  logic [1:0][7:0] cnt_q, cnt_d;
  state_e          state_q, state_d;
  logic            entry_q, exit_q, err_q, entry_d, exit_d, err_d;

`ifdef MALL_DOOR_TIMEOUT_EN
  localparam logic [9:0] TMO_LIMIT = 10'(TIMEOUT_CYCLES);
  logic [9:0] tmo_q, tmo_d;
  logic       tmo_hit;
  assign tmo_hit = (state_q != IDLE) && (state_q != WAIT_CLR) && (tmo_q == TMO_LIMIT);
`endif

  always_comb begin
    // NOTE: defaults first on every combinational output so no path infers a latch.
    db_d  = db_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DB_LAST) begin
        db_d[i]  = ~db_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    entry_d = 1'b0;
    exit_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: case (db_q)
        2'b10:   state_d = IN_A;
        2'b01:   state_d = OUT_B;
        2'b11:   begin state_d = WAIT_CLR; err_d = 1'b1; end
        default: ;
      endcase
      IN_A: case (db_q)
        2'b00:   state_d = IDLE;
        2'b11:   state_d = IN_AB;
        2'b01:   state_d = IN_B;
        default: ;
      endcase
      IN_AB: case (db_q)
        2'b01:   state_d = IN_B;
        2'b10:   state_d = IN_A;
        2'b00:   begin state_d = IDLE; err_d = 1'b1; end
        default: ;
      endcase
      IN_B: case (db_q)
        2'b00:   begin state_d = IDLE; entry_d = 1'b1; end
        2'b11:   state_d = IN_AB;
        2'b10:   state_d = IN_A;
        default: ;
      endcase
      OUT_B: case (db_q)
        2'b00:   state_d = IDLE;
        2'b11:   state_d = OUT_BA;
        2'b10:   state_d = OUT_A;
        default: ;
      endcase
      OUT_BA: case (db_q)
        2'b10:   state_d = OUT_A;
        2'b01:   state_d = OUT_B;
        2'b00:   begin state_d = IDLE; err_d = 1'b1; end
        default: ;
      endcase
      OUT_A: case (db_q)
        2'b00:   begin state_d = IDLE; exit_d = 1'b1; end
        2'b11:   state_d = OUT_BA;
        2'b01:   state_d = OUT_B;
        default: ;
      endcase
      WAIT_CLR: if (db_q == 2'b00) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
`ifdef MALL_DOOR_TIMEOUT_EN
    // A stalled crossing overrides whatever the beam table asked for.
    if (tmo_hit) begin
      state_d = WAIT_CLR;
      entry_d = 1'b0;
      exit_d  = 1'b0;
      err_d   = 1'b1;
    end
    if (state_d != state_q || state_q == IDLE || state_q == WAIT_CLR) tmo_d = '0;
    else                                                              tmo_d = tmo_q + 10'd1;
`endif
  end

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments for every flop so all state updates see pre-edge values.
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      cnt_q   <= '0;
      state_q <= IDLE;
      entry_q <= 1'b0;
      exit_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef MALL_DOOR_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      sync1_q <= {beam_a, beam_b};
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      entry_q <= entry_d;
      exit_q  <= exit_d;
      err_q   <= err_d;
`ifdef MALL_DOOR_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign entry_pulse = entry_q;
  assign exit_pulse  = exit_q;
  assign err_pulse   = err_q;
  assign busy        = (state_q != IDLE);
  assign beam_a_db   = db_q[1];
  assign beam_b_db   = db_q[0];

endmodule

// File: tb/tb_mall_door_sensor.sv
// Bench for mall_door_sensor: directed doorway scenarios plus random beam activity,
// compared every cycle against a direction/last-seen-pair model of the crossing rules.
module tb_mall_door_sensor;

  localparam int DB = 4;

  logic clock = 1'b0;
  logic reset, beam_a, beam_b;
  logic entry_pulse, exit_pulse, err_pulse, busy, beam_a_db, beam_b_db;

  int checks = 0, errors = 0, cyc = 0;
  int n_entry = 0, n_exit = 0, n_err = 0;
  int last_entry_cyc = -1, last_exit_cyc = -1, last_err_cyc = -1;
  bit seen_db_a = 1'b0, seen_busy = 1'b0;

  always #5 clock = ~clock;

  mall_door_sensor #(.DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(1023)) dut (
    .clock(clock), .reset(reset), .beam_a(beam_a), .beam_b(beam_b),
    .entry_pulse(entry_pulse), .exit_pulse(exit_pulse), .err_pulse(err_pulse),
    .busy(busy), .beam_a_db(beam_a_db), .beam_b_db(beam_b_db)
  );

  // Reference model. m_dir: 0 idle, 1 inward, -1 outward, 2 waiting for clear.
  // m_last is the most recent non-empty beam pair seen during the crossing.
  bit [1:0] m_s1, m_s2, m_db, m_last;
  int       m_dir;
  bit       m_entry, m_exit, m_err;
  bit       hist_a[$], hist_b[$];

  function automatic bit window_full(input bit q[$], input bit lvl);
    if (q.size() < DB) return 1'b0;
    for (int k = 1; k <= DB; k++) if (q[q.size() - k] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge();
    bit [1:0] pair, nlast, ndb;
    int       ndir;
    bit       e, x, er;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_db = '0; m_last = '0; m_dir = 0;
      m_entry = 0; m_exit = 0; m_err = 0;
      hist_a.delete(); hist_b.delete();
      return;
    end
    pair = m_db; ndir = m_dir; nlast = m_last; e = 0; x = 0; er = 0;
    case (m_dir)
      0: begin
        if (pair == 2'b10)      begin ndir = 1;  nlast = pair; end
        else if (pair == 2'b01) begin ndir = -1; nlast = pair; end
        else if (pair == 2'b11) begin ndir = 2;  er = 1; end
      end
      2: if (pair == 2'b00) ndir = 0;
      default: begin
        if (pair != 2'b00) nlast = pair;
        else begin
          // Leaving an empty doorway: both-blocked last means an aborted sequence,
          // far-side last means a completed crossing, near-side last is a back-out.
          if (m_last == 2'b11)                        er = 1;
          else if (m_dir == 1  && m_last == 2'b01)    e = 1;
          else if (m_dir == -1 && m_last == 2'b10)    x = 1;
          ndir = 0;
        end
      end
    endcase
    ndb = m_db;
    hist_a.push_back(m_s2[1]);
    hist_b.push_back(m_s2[0]);
    if (hist_a.size() > DB) void'(hist_a.pop_front());
    if (hist_b.size() > DB) void'(hist_b.pop_front());
    if (window_full(hist_a, m_db[1])) begin ndb[1] = ~m_db[1]; hist_a.delete(); end
    if (window_full(hist_b, m_db[0])) begin ndb[0] = ~m_db[0]; hist_b.delete(); end
    m_db = ndb; m_s2 = m_s1; m_s1 = {beam_a, beam_b};
    m_dir = ndir; m_last = nlast;
    m_entry = e; m_exit = x; m_err = er;
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    model_edge();
    cyc++;
    #1;
    cmp("entry_pulse", entry_pulse, m_entry);
    cmp("exit_pulse",  exit_pulse,  m_exit);
    cmp("err_pulse",   err_pulse,   m_err);
    cmp("busy",        busy,        m_dir != 0);
    cmp("beam_a_db",   beam_a_db,   m_db[1]);
    cmp("beam_b_db",   beam_b_db,   m_db[0]);
    if (entry_pulse) begin n_entry++; last_entry_cyc = cyc; end
    if (exit_pulse)  begin n_exit++;  last_exit_cyc  = cyc; end
    if (err_pulse)   begin n_err++;   last_err_cyc   = cyc; end
    if (beam_a_db)   seen_db_a = 1'b1;
    if (busy)        seen_busy = 1'b1;
  endtask

  task automatic hold(input bit a, input bit b, input int n);
    beam_a = a; beam_b = b;
    repeat (n) cycle();
  endtask

  initial begin
    int e0, x0, r0, t;
    reset = 1'b1; beam_a = 1'b0; beam_b = 1'b0;
    cycle(); cycle();
    cmp("reset_outputs", {entry_pulse, exit_pulse, err_pulse, busy, beam_a_db, beam_b_db}, 0);
    reset = 1'b0;
    hold(0, 0, 5);

    // Entry walk: A, A+B, B, clear -> one entry pulse 2+DB+1 edges after B clears.
    e0 = n_entry; x0 = n_exit; r0 = n_err;
    hold(1, 0, 20); hold(1, 1, 20); hold(0, 1, 20);
    t = cyc; hold(0, 0, 20);
    cmp("entry_walk_count", n_entry - e0, 1);
    cmp("entry_walk_latency", last_entry_cyc - t, 2 + DB + 1);
    cmp("entry_walk_no_other", (n_exit - x0) + (n_err - r0), 0);

    // Exit walk.
    e0 = n_entry; x0 = n_exit; r0 = n_err;
    hold(0, 1, 20); hold(1, 1, 20); hold(1, 0, 20);
    t = cyc; hold(0, 0, 20);
    cmp("exit_walk_count", n_exit - x0, 1);
    cmp("exit_walk_latency", last_exit_cyc - t, 2 + DB + 1);
    cmp("exit_walk_no_other", (n_entry - e0) + (n_err - r0), 0);

    // Glitch shorter than the debounce window never reaches the FSM.
    seen_db_a = 1'b0; seen_busy = 1'b0;
    hold(1, 0, 3); hold(0, 0, 20);
    cmp("glitch_db_a", seen_db_a, 0);
    cmp("glitch_busy", seen_busy, 0);

    // Back-out: busy while A is held, no pulse at all.
    e0 = n_entry; x0 = n_exit; r0 = n_err; seen_busy = 1'b0;
    hold(1, 0, 20); hold(0, 0, 20);
    cmp("backout_busy_seen", seen_busy, 1);
    cmp("backout_pulses", (n_entry - e0) + (n_exit - x0) + (n_err - r0), 0);

    // Simultaneous block -> error, hold until clear, then a normal entry.
    e0 = n_entry; r0 = n_err;
    t = cyc; hold(1, 1, 20);
    cmp("simul_err_count", n_err - r0, 1);
    cmp("simul_err_latency", last_err_cyc - t, 2 + DB + 1);
    cmp("simul_busy_held", busy, 1);
    hold(0, 0, 20);
    hold(1, 0, 20); hold(1, 1, 20); hold(0, 1, 20); hold(0, 0, 20);
    cmp("simul_then_entry", n_entry - e0, 1);

    // Reset mid-crossing discards the crossing.
    e0 = n_entry;
    hold(1, 0, 20); hold(1, 1, 20); hold(0, 1, 20);
    reset = 1'b1; cycle();
    cmp("midreset_outputs", {entry_pulse, exit_pulse, err_pulse, busy, beam_a_db, beam_b_db}, 0);
    reset = 1'b0;
    hold(0, 0, 20);
    cmp("midreset_no_entry", n_entry - e0, 0);

    // Random beam activity including short glitches and occasional resets.
    for (int s = 0; s < 400; s++) begin
      if ($urandom_range(0, 29) == 0) begin
        reset = 1'b1; cycle(); reset = 1'b0;
      end
      hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 12));
    end
    hold(0, 0, 30);
    cmp("final_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
